// File: rtl/vip_scan_reduce.sv
// Memory scanner/reducer: streams Len words from Base upward out of an async-read
// memory and reduces them to one signed Result (sum with saturation, max, min, argmax).
module vip_scan_reduce #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int ACC_W  = 42
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Start,
  input  logic [1:0]        Mode,
  input  logic [ADDR_W-1:0] Base,
  input  logic [ADDR_W:0]   Len,
  input  logic [DATA_W-1:0] Data,
  output logic              En,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] Result,
  output logic              Finish,
  output logic              Busy,
  output logic              Ovf
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {M_SUM = 2'b00, M_MAX = 2'b01, M_MIN = 2'b10, M_ARGMAX = 2'b11} mode_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  state_t                    r_state;
  mode_t                     r_mode;
  logic [ADDR_W:0]           r_cnt;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_best;
  logic [ADDR_W-1:0]         r_best_addr;
  logic                      r_first;
  logic                      r_pend;

  logic signed [DATA_W-1:0]  w_data;
  logic signed [ACC_W-1:0]   w_data_ext;
  logic                      w_take;
  logic [DATA_W-1:0]         w_res;
  logic                      w_ovf;

  assign w_data     = $signed(Data);
  assign w_data_ext = {{(ACC_W-DATA_W){Data[DATA_W-1]}}, Data};

  // Min replaces on strictly smaller; max/argmax on strictly larger so ties keep the earlier address.
  assign w_take = r_first || ((r_mode == M_MIN) ? (w_data < r_best) : (w_data > r_best));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (r_mode)
      M_SUM: begin
        if (r_acc > ACC_MAX) begin
          w_res = {1'b0, {(DATA_W-1){1'b1}}};
          w_ovf = 1'b1;
        end else if (r_acc < ACC_MIN) begin
          w_res = {1'b1, {(DATA_W-1){1'b0}}};
          w_ovf = 1'b1;
        end else begin
          w_res = r_acc[DATA_W-1:0];
        end
      end
      M_MAX, M_MIN: w_res = r_best;
      default:      w_res = {{(DATA_W-ADDR_W){1'b0}}, r_best_addr};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_mode      <= M_SUM;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_best      <= '0;
      r_best_addr <= '0;
      r_first     <= 1'b0;
      r_pend      <= 1'b0;
      En          <= 1'b0;
      Addr        <= '0;
      Result      <= '0;
      Finish      <= 1'b0;
      Busy        <= 1'b0;
      Ovf         <= 1'b0;
    end else begin
      // One-cycle finalise stage after the last word; a Start in the same cycle overrides it below.
      if (r_pend) begin
        Finish <= 1'b1;
        Result <= w_res;
        Ovf    <= w_ovf;
        r_pend <= 1'b0;
      end
      case (r_state)
        IDLE, DONE: begin
          if (Start) begin
            r_mode      <= mode_t'(Mode);
            Addr        <= Base;
            r_cnt       <= Len;
            r_acc       <= '0;
            r_best      <= '0;
            r_best_addr <= '0;
            r_first     <= 1'b1;
            Finish      <= 1'b0;
            Result      <= '0;
            Ovf         <= 1'b0;
            r_pend      <= (Len == '0);
            if (Len != '0) begin
              En      <= 1'b1;
              Busy    <= 1'b1;
              r_state <= SCAN;
            end else begin
              r_state <= DONE;
            end
          end
        end
        SCAN: begin
          r_acc   <= r_acc + w_data_ext;
          r_first <= 1'b0;
          if (w_take) begin
            r_best      <= w_data;
            r_best_addr <= Addr;
          end
          Addr  <= Addr + ADDR_W'(1);
          r_cnt <= r_cnt - (ADDR_W+1)'(1);
          if (r_cnt == (ADDR_W+1)'(1)) begin
            En      <= 1'b0;
            Busy    <= 1'b0;
            r_pend  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vip_scan_reduce.sv
// Scoreboard bench for vip_scan_reduce: a behavioural model pushes the expected result
// per scan, and the entry is popped and compared when Finish rises.
module tb_vip_scan_reduce;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic              ovf;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   len;
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] result;
  logic              finish;
  logic              busy;
  logic              ovf;

  logic [DATA_W-1:0] mem [DEPTH];
  wire  [DATA_W-1:0] data_bus = en ? mem[addr] : 'z;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  vip_scan_reduce #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(42)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Start  (start),
    .Mode   (mode),
    .Base   (base),
    .Len    (len),
    .Data   (data_bus),
    .En     (en),
    .Addr   (addr),
    .Result (result),
    .Finish (finish),
    .Busy   (busy),
    .Ovf    (ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [1:0] m, input int b, input int n);
    exp_t   e;
    longint acc  = 0;
    int     best = 0;
    int     barg = 0;
    for (int i = 0; i < n; i++) begin
      int a = (b + i) % DEPTH;
      int v = $signed(mem[a]);
      acc += v;
      if (i == 0 || ((m == 2'b10) ? (v < best) : (v > best))) begin
        best = v;
        barg = a;
      end
    end
    e.ovf = 1'b0;
    case (m)
      2'b00: begin
        if (acc > SMAX)      begin e.res = 32'h7FFF_FFFF; e.ovf = 1'b1; end
        else if (acc < SMIN) begin e.res = 32'h8000_0000; e.ovf = 1'b1; end
        else                 e.res = acc[31:0];
      end
      2'b01, 2'b10: e.res = best;
      default:      e.res = barg;
    endcase
    return e;
  endfunction

  // Called at posedge+1. Optionally pulses a bogus Start mid-scan, which must be ignored.
  task automatic run_scan(input logic [1:0] m, input int b, input int n, input bit inject);
    exp_t e;
    int   en_cnt = 0;
    int   fin_s  = -1;
    sb.push_back(model(m, b, n));
    start = 1'b1; mode = m; base = ADDR_W'(b); len = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int s = 0; s <= n + 20; s++) begin
      if (s > 0) begin @(posedge clk); #1; end
      check("no_x", {62'd0, $isunknown({en, addr, result, finish, busy, ovf})}, 64'd0);
      if (s == 0) check("finish_cleared", {63'd0, finish}, 64'd0);
      if (inject && s == 5) begin
        start = 1'b1; mode = ~m; base = ADDR_W'(b + 7); len = 11'd3;
      end
      if (inject && s == 6) start = 1'b0;
      if (en) begin
        check("addr_seq", {54'd0, addr}, 64'((b + s) % DEPTH));
        en_cnt++;
      end
      if (finish) begin
        fin_s = s;
        break;
      end
    end
    check("en_cycles", 64'(en_cnt), 64'(n));
    check("latency", 64'(fin_s), 64'(n + 1));
    e = sb.pop_front();
    if (finish) begin
      check("result", {32'd0, result}, {32'd0, e.res});
      check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
      check("busy_done", {63'd0, busy}, 64'd0);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] wrap_data [8];
    rst_n = 1'b0; start = 1'b0; mode = 2'b00; base = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {22'd0, en, addr, result, finish, busy, ovf}, 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-memory sum of 0..1023
    run_scan(2'b00, 0, 1024, 1'b0);

    // Async reset mid-scan after 10 words
    start = 1'b1; mode = 2'b00; base = '0; len = 11'd1024;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy_mid", {63'd0, busy}, 64'd1);
    #1 rst_n = 1'b0;
    #1 check("async_reset", {22'd0, en, addr, result, finish, busy, ovf}, 64'd0);
    @(posedge clk); #1;
    check("reset_held", {22'd0, en, addr, result, finish, busy, ovf}, 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_scan(2'b00, 100, 40, 1'b1);

    // Saturation both ways
    for (int i = 0; i < 4; i++) mem[i] = 32'h7FFF_FFFF;
    run_scan(2'b00, 0, 4, 1'b0);
    for (int i = 0; i < 4; i++) mem[i] = 32'h8000_0000;
    run_scan(2'b00, 0, 4, 1'b0);

    // Wrap-around max/min/argmax: data {5,-3,9,-9,9,0,1,2} at 1020..1023,0..3
    wrap_data = '{32'd5, -32'sd3, 32'd9, -32'sd9, 32'd9, 32'd0, 32'd1, 32'd2};
    for (int i = 0; i < 8; i++) mem[(1020 + i) % DEPTH] = wrap_data[i];
    run_scan(2'b01, 1020, 8, 1'b0);
    run_scan(2'b10, 1020, 8, 1'b0);
    run_scan(2'b11, 1020, 8, 1'b0);
    check("argmax_first9", {32'd0, result}, 64'd1022);

    // Len==0 in every mode, back-to-back from DONE
    for (int m = 0; m < 4; m++) run_scan(2'(m), 1020, 0, 1'b0);

    // Random contents and scans
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int k = 0; k < 8; k++)
      run_scan(2'($urandom_range(0, 3)), int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 60)), 1'b0);
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom_range(0, 255);
    run_scan(2'b11, 700, 1024, 1'b0);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
